// File: rtl/bsg_disassembler.sv
// Wide-word to ring-beat disassembler: takes one num_beats_p*ring_width_p word over ready/valid
// and emits it as num_beats_p beats over valid/yumi, least-significant slice first.
module bsg_disassembler #(
  parameter int ring_width_p = 64,
  parameter int num_beats_p  = 4,
  parameter int id_p         = 0
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                en_i,
  input  logic                                v_i,
  input  logic [num_beats_p*ring_width_p-1:0] data_i,
  output logic                                ready_o,
  output logic                                v_o,
  output logic [ring_width_p-1:0]             data_o,
  output logic                                last_o,
  input  logic                                yumi_i
);

  localparam int cnt_w_lp = $clog2(num_beats_p);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(num_beats_p - 1);

  if (num_beats_p < 2 || id_p < 0) begin : g_param_check
    $error("bsg_disassembler: num_beats_p must be >= 2 and id_p non-negative");
  end

  typedef enum logic {IDLE, SEND} state_e;

  state_e                                   state_r;
  logic [cnt_w_lp-1:0]                      cnt_r;
  logic [num_beats_p-1:0][ring_width_p-1:0] buf_r;
  logic                                     accept;
  logic                                     is_last;

  // Reset gates the handshake outputs combinationally so nothing is offered during the reset cycle.
  assign ready_o = (state_r == IDLE) & en_i & ~reset_i;
  assign v_o     = (state_r == SEND) & ~reset_i;
  assign is_last = (cnt_r == last_cnt_lp);
  assign last_o  = v_o & is_last;
  assign data_o  = buf_r[cnt_r];
  assign accept  = v_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: if (accept) begin
          state_r <= SEND;
          cnt_r   <= '0;
        end
        SEND: if (yumi_i) begin
          if (is_last) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + cnt_w_lp'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // NOTE: the word buffer is pure datapath and deliberately has no reset; v_o qualifies its contents.
  always_ff @(posedge clk_i) begin
    if (accept) buf_r <= data_i;
  end

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
